// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Purpose  : Default VGA 640x480 timing, derived line/frame constants and the
//             receiver lock-state encoding shared by the sync receiver.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_BOTTOM  = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_TOP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_H_SS    = VGA_H_DISPLAY + VGA_H_FRONT;
    localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_BOTTOM + VGA_V_SYNC + VGA_V_TOP;
    localparam int VGA_V_SS    = VGA_V_DISPLAY + VGA_V_BOTTOM;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        H_ACQ    = 2'd1,
        V_ACQ    = 2'd2,
        LOCKED   = 2'd3
    } vsr_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module   : sync_edge_detect
//  Purpose  : Polarity-normalises one sync input and flags its assertion edge.
//             With VSR_INPUT_SYNC_EN defined the input first crosses a 2-flop
//             synchronizer (adds 2 cycles of latency).
//  Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
    parameter bit SYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sync,
    output logic o_asserted,
    output logic o_edge
);

    logic w_raw_asserted;
    logic w_level;
    logic r_prev;

    assign w_raw_asserted = (i_sync == SYNC_POL);

`ifdef VSR_INPUT_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], w_raw_asserted};
        end
    end

    assign w_level = r_sync[1];
`else
    assign w_level = w_raw_asserted;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_asserted = w_level;
    assign o_edge     = w_level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/video_sync_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : video_sync_receiver
//  Purpose  : Recovers hpos/vpos/display_on from raw hsync/vsync, locks to the
//             source and flags timing violations. Optional input synchronizer
//             is enabled by defining VSR_INPUT_SYNC_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module video_sync_receiver
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY  = VGA_H_DISPLAY,
    parameter int H_FRONT    = VGA_H_FRONT,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BACK     = VGA_H_BACK,
    parameter int V_DISPLAY  = VGA_V_DISPLAY,
    parameter int V_BOTTOM   = VGA_V_BOTTOM,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_TOP      = VGA_V_TOP,
    parameter bit SYNC_POL   = 1'b0,
    parameter int LOCK_LINES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       display_on,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_error
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int H_SS    = H_DISPLAY + H_FRONT;
    localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
    localparam int V_SS    = V_DISPLAY + V_BOTTOM;
    localparam int CNT_W   = $clog2(LOCK_LINES + 1);

    localparam logic [9:0]       c_h_last    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       c_v_last    = 10'(V_TOTAL - 1);
    localparam logic [9:0]       c_h_ss      = 10'(H_SS);
    localparam logic [9:0]       c_v_ss      = 10'(V_SS);
    localparam logic [9:0]       c_h_disp    = 10'(H_DISPLAY);
    localparam logic [9:0]       c_v_disp    = 10'(V_DISPLAY);
    localparam logic [CNT_W-1:0] c_lock_cnt  = CNT_W'(LOCK_LINES);

    vsr_state_t       r_state;
    vsr_state_t       w_state_next;
    logic [CNT_W-1:0] r_good_cnt;
    logic [CNT_W-1:0] w_good_cnt_next;
    logic [CNT_W-1:0] w_good_cnt_inc;
    logic [9:0]       r_hpos;
    logic [9:0]       r_vpos;
    logic [9:0]       w_hpos_inc;
    logic [9:0]       w_vpos_inc;
    logic [9:0]       w_hpos_next;
    logic [9:0]       w_vpos_next;
    logic             r_display_on;
    logic             r_frame_start;
    logic             r_sync_error;
    logic             w_h_asserted;
    logic             w_h_edge;
    logic             w_v_asserted_unused;
    logic             w_v_edge;
    logic             w_h_wrap;
    logic             w_h_viol;
    logic             w_v_viol;
    logic             w_viol;
    logic             w_locked_next;

    sync_edge_detect #(
        .SYNC_POL   (SYNC_POL)
    ) u_hsync_edge (
        .clk        (clk),
        .reset      (reset),
        .i_sync     (hsync_in),
        .o_asserted (w_h_asserted),
        .o_edge     (w_h_edge)
    );

    sync_edge_detect #(
        .SYNC_POL   (SYNC_POL)
    ) u_vsync_edge (
        .clk        (clk),
        .reset      (reset),
        .i_sync     (vsync_in),
        .o_asserted (w_v_asserted_unused),
        .o_edge     (w_v_edge)
    );

    // Free-running counters; a sync edge overrides the natural increment.
    assign w_hpos_inc  = (r_hpos == c_h_last) ? 10'd0 : r_hpos + 10'd1;
    assign w_h_wrap    = !w_h_edge && (r_hpos == c_h_last);
    assign w_vpos_inc  = !w_h_wrap ? r_vpos :
                         ((r_vpos == c_v_last) ? 10'd0 : r_vpos + 10'd1);
    assign w_hpos_next = w_h_edge ? c_h_ss : w_hpos_inc;
    assign w_vpos_next = w_v_edge ? c_v_ss : w_vpos_inc;

    assign w_h_viol = (r_state != UNLOCKED) &&
                      ((w_h_edge && (w_hpos_inc != c_h_ss)) ||
                       ((w_hpos_inc == c_h_ss) && !w_h_asserted));
    assign w_v_viol = (r_state == LOCKED) && w_v_edge && (w_vpos_inc != c_v_ss);
    assign w_viol   = w_h_viol || w_v_viol;

    assign w_good_cnt_inc = r_good_cnt + 1'b1;

    always_comb begin
        w_state_next    = r_state;
        w_good_cnt_next = r_good_cnt;
        case (r_state)
            UNLOCKED: begin
                if (w_h_edge) begin
                    w_state_next    = H_ACQ;
                    w_good_cnt_next = '0;
                end
            end
            H_ACQ: begin
                if (w_h_viol) begin
                    w_good_cnt_next = '0;
                end else if (w_h_edge) begin
                    w_good_cnt_next = w_good_cnt_inc;
                    if (w_good_cnt_inc == c_lock_cnt) begin
                        w_state_next = V_ACQ;
                    end
                end
            end
            V_ACQ: begin
                if (w_h_viol) begin
                    w_state_next    = H_ACQ;
                    w_good_cnt_next = '0;
                end else if (w_v_edge) begin
                    w_state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (w_viol) begin
                    w_state_next    = H_ACQ;
                    w_good_cnt_next = '0;
                end
            end
            default: begin
                w_state_next    = UNLOCKED;
                w_good_cnt_next = '0;
            end
        endcase
    end

    assign w_locked_next = (w_state_next == LOCKED);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= UNLOCKED;
            r_good_cnt    <= '0;
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_display_on  <= 1'b0;
            r_frame_start <= 1'b0;
            r_sync_error  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_good_cnt    <= w_good_cnt_next;
            r_hpos        <= w_hpos_next;
            r_vpos        <= w_vpos_next;
            // Flags are computed from next-state values so they line up with hpos/vpos.
            r_display_on  <= w_locked_next && (w_hpos_next < c_h_disp) &&
                             (w_vpos_next < c_v_disp);
            r_frame_start <= w_locked_next && (w_hpos_next == 10'd0) &&
                             (w_vpos_next == 10'd0);
            r_sync_error  <= w_viol;
        end
    end

    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign display_on  = r_display_on;
    assign locked      = (r_state == LOCKED);
    assign frame_start = r_frame_start;
    assign sync_error  = r_sync_error;

endmodule
`default_nettype wire

// File: tb/tb_video_sync_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_video_sync_receiver
//  Purpose  : Bench for video_sync_receiver driven by a reduced-size timing
//             source; follows VSR_INPUT_SYNC_EN for the expected latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_video_sync_receiver;

    localparam int HD = 16, HF = 4, HS = 6, HB = 6;
    localparam int HT = HD + HF + HS + HB;
    localparam int HSS = HD + HF;
    localparam int VD = 12, VB = 2, VS = 2, VTP = 4;
    localparam int VT = VD + VB + VS + VTP;
    localparam int VSS = VD + VB;
    localparam int LOCKN = 4;
    localparam int FRAME = HT * VT;
`ifdef VSR_INPUT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       display_on;
    logic       locked;
    logic       frame_start;
    logic       sync_error;

    video_sync_receiver #(
        .H_DISPLAY  (HD),  .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_DISPLAY  (VD),  .V_BOTTOM(VB), .V_SYNC (VS), .V_TOP  (VTP),
        .SYNC_POL   (1'b0),
        .LOCK_LINES (LOCKN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .hpos        (hpos),
        .vpos        (vpos),
        .display_on  (display_on),
        .locked      (locked),
        .frame_start (frame_start),
        .sync_error  (sync_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       disp;
        logic       fs;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   gh, gv;
    int   fault_mode;   // 0 none, 1 suppress hsync, 2 hsync 3 cycles early
    int   fault_line;
    bit   gen_on;
    int   asserts;
    int   failures;

    // Source model: drive active-low syncs for the current position and queue
    // what the receiver should show once the pipeline latency has elapsed.
    task automatic drive_gen();
        int   lo, hi;
        logic hs_act, vs_act;
        exp_t e;
        lo = HSS;
        hi = HSS + HS;
        if (fault_mode == 2 && gv == fault_line) begin
            lo = HSS - 3;
            hi = HSS + HS - 3;
        end
        hs_act   = (gh >= lo) && (gh < hi) && !(fault_mode == 1 && gv == fault_line);
        vs_act   = (gv >= VSS) && (gv < VSS + VS);
        hsync_in = ~hs_act;
        vsync_in = ~vs_act;
        e.h    = 10'(gh);
        e.v    = 10'(gv);
        e.disp = (gh < HD) && (gv < VD);
        e.fs   = (gh == 0) && (gv == 0);
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (gen_on) begin
            if (sb_q.size() >= LAT) cur = sb_q.pop_front();
            if (gh == HT - 1) begin
                gh = 0;
                if (fault_mode != 0 && gv == fault_line) fault_mode = 0;
                gv = (gv == VT - 1) ? 0 : gv + 1;
            end else begin
                gh = gh + 1;
            end
            drive_gen();
        end
    endtask

    task automatic run_until_locked(input int max_cycles, output int n_err);
        int n;
        n     = 0;
        n_err = 0;
        while (locked !== 1'b1 && n < max_cycles) begin
            tick();
            n = n + 1;
            if (sync_error === 1'b1) n_err = n_err + 1;
        end
    endtask

    task automatic run_until_error(input int max_cycles);
        int n;
        n = 0;
        while (sync_error !== 1'b1 && n < max_cycles) begin
            tick();
            n = n + 1;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        gen_on   = 1'b0;
        repeat (3) tick();
        asserts++; if (hpos !== 10'd0) begin failures++; $display("FAIL reset_hpos: got %0d want 0", hpos); end
        asserts++; if (vpos !== 10'd0) begin failures++; $display("FAIL reset_vpos: got %0d want 0", vpos); end
        asserts++; if (display_on !== 1'b0) begin failures++; $display("FAIL reset_display_on: got %b want 0", display_on); end
        asserts++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b want 0", locked); end
        asserts++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
        asserts++; if (sync_error !== 1'b0) begin failures++; $display("FAIL reset_sync_error: got %b want 0", sync_error); end
    endtask

    task automatic test_acquire();
        int n_err;
        gh = 0; gv = 0; fault_mode = 0;
        sb_q.delete();
        gen_on = 1'b1;
        reset  = 1'b1;
        drive_gen();
        run_until_locked(3 * FRAME, n_err);
        asserts++; if (locked !== 1'b1) begin failures++; $display("FAIL acquire_lock: locked=%b want 1", locked); end
        asserts++;
        if ({cur.h, cur.v, hpos, vpos} !== {10'd0, 10'(VSS), 10'd0, 10'(VSS)}) begin
            failures++;
            $display("FAIL acquire_position: source h=%0d v=%0d dut h=%0d v=%0d, want source and dut at h=0 v=%0d",
                     cur.h, cur.v, hpos, vpos, VSS);
        end
        asserts++; if (n_err != 0) begin failures++; $display("FAIL acquire_errors: got %0d sync_error pulses want 0", n_err); end
    endtask

    task automatic test_track(input int frames);
        int fs_cnt;
        bit bad;
        fs_cnt = 0;
        bad    = 1'b0;
        for (int i = 0; i < frames * FRAME; i++) begin
            tick();
            if (frame_start === 1'b1) fs_cnt = fs_cnt + 1;
            if (!bad) begin
                asserts++;
                if ({hpos, vpos, display_on, frame_start, locked, sync_error} !==
                    {cur.h, cur.v, cur.disp, cur.fs, 1'b1, 1'b0}) begin
                    failures++;
                    bad = 1'b1;
                    $display("FAIL track: got h=%0d v=%0d disp=%b fs=%b lock=%b err=%b, want h=%0d v=%0d disp=%b fs=%b lock=1 err=0",
                             hpos, vpos, display_on, frame_start, locked, sync_error,
                             cur.h, cur.v, cur.disp, cur.fs);
                end
            end
        end
        asserts++; if (fs_cnt != frames) begin failures++; $display("FAIL frame_start_count: got %0d want %0d", fs_cnt, frames); end
    endtask

    task automatic test_missing_hsync();
        int n_err;
        fault_line = 3;
        fault_mode = 1;
        run_until_error(2 * FRAME);
        asserts++; if (sync_error !== 1'b1) begin failures++; $display("FAIL missing_error: sync_error=%b want 1", sync_error); end
        asserts++;
        if ({hpos, vpos, locked} !== {10'(HSS), 10'(fault_line), 1'b0}) begin
            failures++;
            $display("FAIL missing_where: got h=%0d v=%0d locked=%b want h=%0d v=%0d locked=0",
                     hpos, vpos, locked, HSS, fault_line);
        end
        tick();
        asserts++; if (sync_error !== 1'b0) begin failures++; $display("FAIL missing_pulse_width: sync_error=%b want 0", sync_error); end
        run_until_locked(2 * FRAME, n_err);
        asserts++;
        if ({locked, cur.h, cur.v} !== {1'b1, 10'd0, 10'(VSS)}) begin
            failures++;
            $display("FAIL missing_relock: locked=%b at source h=%0d v=%0d want locked=1 at h=0 v=%0d",
                     locked, cur.h, cur.v, VSS);
        end
        asserts++; if (n_err != 0) begin failures++; $display("FAIL missing_extra_errors: got %0d want 0", n_err); end
    endtask

    task automatic test_early_hsync();
        int n_err;
        fault_line = 2;
        fault_mode = 2;
        run_until_error(2 * FRAME);
        asserts++;
        if ({sync_error, locked, hpos, vpos, cur.h} !==
            {1'b1, 1'b0, 10'(HSS), 10'(fault_line), 10'(HSS - 3)}) begin
            failures++;
            $display("FAIL early_realign: err=%b lock=%b h=%0d v=%0d source_h=%0d want err=1 lock=0 h=%0d v=%0d source_h=%0d",
                     sync_error, locked, hpos, vpos, cur.h, HSS, fault_line, HSS - 3);
        end
        tick();
        asserts++;
        if ({sync_error, locked, hpos} !== {1'b0, 1'b0, 10'(HSS + 1)}) begin
            failures++;
            $display("FAIL early_after: err=%b lock=%b h=%0d want err=0 lock=0 h=%0d",
                     sync_error, locked, hpos, HSS + 1);
        end
        run_until_locked(2 * FRAME, n_err);
        asserts++;
        if ({locked, cur.h, cur.v} !== {1'b1, 10'd0, 10'(VSS)}) begin
            failures++;
            $display("FAIL early_relock: locked=%b at source h=%0d v=%0d want locked=1 at h=0 v=%0d",
                     locked, cur.h, cur.v, VSS);
        end
    endtask

    task automatic test_reset_midline();
        int n;
        int n_err;
        n = 0;
        while (hpos !== 10'd8 && n < 2 * HT) begin
            tick();
            n = n + 1;
        end
        asserts++; if (hpos !== 10'd8 || locked !== 1'b1) begin failures++; $display("FAIL midline_reach: h=%0d lock=%b want h=8 lock=1", hpos, locked); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        asserts++;
        if ({hpos, vpos, display_on, locked, frame_start, sync_error} !== 24'd0) begin
            failures++;
            $display("FAIL midline_reset: h=%0d v=%0d disp=%b lock=%b fs=%b err=%b want all 0",
                     hpos, vpos, display_on, locked, frame_start, sync_error);
        end
        run_until_locked(3 * FRAME, n_err);
        asserts++;
        if ({locked, cur.h, cur.v} !== {1'b1, 10'd0, 10'(VSS)}) begin
            failures++;
            $display("FAIL midline_relock: locked=%b at source h=%0d v=%0d want locked=1 at h=0 v=%0d",
                     locked, cur.h, cur.v, VSS);
        end
        asserts++; if (n_err != 0) begin failures++; $display("FAIL midline_errors: got %0d want 0", n_err); end
    endtask

    initial begin
        asserts    = 0;
        failures   = 0;
        fault_mode = 0;
        fault_line = 0;
        gh         = 0;
        gv         = 0;
        cur        = '0;
        test_reset();
        test_acquire();
        test_track(2);
        test_missing_hsync();
        test_early_hsync();
        test_reset_midline();
        test_track(1);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
`default_nettype wire
